// File: rtl/ddr_tensor_writer.sv
`default_nettype none
// ============================================================================
// Module      : ddr_tensor_writer
// Description : Converts the compute array's result stream (N_KERNEL pixels
//               per beat) into {addr, data} beats for the DDR write bridge.
//               Walks an HWC tensor in channel-group-major order, using
//               running address accumulators and a single output register
//               with full valid/ready backpressure.
// Options     : `WRITER_STATS_EN adds stat_beats / stat_stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr_tensor_writer #(
  parameter int N_KERNEL   = 4,
  parameter int B_PIXEL    = 16,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int W_BITS     = 10,
  parameter int H_BITS     = 10,
  parameter int C_BITS     = 12
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [ADDR_WIDTH-1:0]            cfg_base_addr,
  input  logic [W_BITS-1:0]                cfg_w,
  input  logic [H_BITS-1:0]                cfg_h,
  input  logic [C_BITS-1:0]                cfg_c,
  input  logic                             cfg_start,
  output logic                             cfg_busy,
  output logic                             cfg_done,
  input  logic                             s_valid,
  input  logic [DATA_WIDTH-1:0]            s_data,
  output logic                             s_ready,
  output logic [DATA_WIDTH+ADDR_WIDTH-1:0] m_axis_tdata,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             m_axis_tlast
`ifdef WRITER_STATS_EN
  ,
  output logic [31:0]                      stat_beats,
  output logic [31:0]                      stat_stall
`endif
);

  localparam int c_BPB = B_PIXEL / 8;
  localparam int c_PW  = W_BITS + H_BITS;
  localparam logic [ADDR_WIDTH-1:0] c_GROUP_STEP = ADDR_WIDTH'(N_KERNEL * c_BPB);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                            r_state;
  logic [ADDR_WIDTH-1:0]             r_base;
  logic [ADDR_WIDTH-1:0]             r_stride;
  logic [c_PW-1:0]                   r_p_max;
  logic [C_BITS-1:0]                 r_g_max;
  logic [c_PW-1:0]                   r_p;
  logic [C_BITS-1:0]                 r_g;
  logic [ADDR_WIDTH-1:0]             r_dxy;
  logic [ADDR_WIDTH-1:0]             r_dc;
  logic                              r_tvalid;
  logic                              r_tlast;
  logic [DATA_WIDTH+ADDR_WIDTH-1:0]  r_tdata;
  logic                              r_busy;
  logic                              r_done;

  logic                              w_s_fire;
  logic                              w_m_fire;
  logic                              w_p_end;
  logic                              w_last;
  logic                              w_zero_shape;
  logic [ADDR_WIDTH-1:0]             w_addr;
  logic [c_PW-1:0]                   w_p_total;
  logic [ADDR_WIDTH-1:0]             w_stride;
  logic [C_BITS-1:0]                 w_g_max;

  // Shape products are only evaluated while idle, so they stay out of the beat loop.
  assign w_p_total    = c_PW'(cfg_w) * c_PW'(cfg_h);
  assign w_stride     = ADDR_WIDTH'(cfg_c) * ADDR_WIDTH'(c_BPB);
  assign w_g_max      = (cfg_c - C_BITS'(1)) / C_BITS'(N_KERNEL);
  assign w_zero_shape = (cfg_w == '0) | (cfg_h == '0) | (cfg_c == '0);

  assign s_ready  = (r_state == S_RUN) & (~r_tvalid | m_axis_tready);
  assign w_s_fire = s_valid & s_ready;
  assign w_m_fire = r_tvalid & m_axis_tready;
  assign w_p_end  = (r_p == r_p_max);
  assign w_last   = w_p_end & (r_g == r_g_max);
  assign w_addr   = r_base + r_dxy + r_dc;

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign cfg_busy      = r_busy;
  assign cfg_done      = r_done;

  // Control FSM, address accumulators and the single output register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_base   <= '0;
      r_stride <= '0;
      r_p_max  <= '0;
      r_g_max  <= '0;
      r_p      <= '0;
      r_g      <= '0;
      r_dxy    <= '0;
      r_dc     <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tdata  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      // Load on accept; a simultaneous drain is covered by the reload.
      if (w_s_fire) begin
        r_tvalid <= 1'b1;
        r_tdata  <= {w_addr, s_data};
        r_tlast  <= w_last;
      end else if (w_m_fire) begin
        r_tvalid <= 1'b0;
        r_tlast  <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (cfg_start) begin
            r_base   <= cfg_base_addr;
            r_stride <= w_stride;
            r_p_max  <= w_p_total - c_PW'(1);
            r_g_max  <= w_g_max;
            r_p      <= '0;
            r_g      <= '0;
            r_dxy    <= '0;
            r_dc     <= '0;
            r_busy   <= 1'b1;
            if (w_zero_shape) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (w_s_fire) begin
            if (w_p_end) begin
              r_p   <= '0;
              r_dxy <= '0;
              r_g   <= r_g + C_BITS'(1);
              r_dc  <= r_dc + c_GROUP_STEP;
            end else begin
              r_p   <= r_p + c_PW'(1);
              r_dxy <= r_dxy + r_stride;
            end
            if (w_last) r_state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (w_m_fire) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef WRITER_STATS_EN
  logic [31:0] r_stat_beats;
  logic [31:0] r_stat_stall;

  // Saturating beat and stall counters, cleared by reset or a new run.
  always_ff @(posedge clk) begin
    if (!rstn || (r_state == S_IDLE && cfg_start)) begin
      r_stat_beats <= '0;
      r_stat_stall <= '0;
    end else begin
      if (w_m_fire && (r_stat_beats != '1))
        r_stat_beats <= r_stat_beats + 32'd1;
      if (r_tvalid && !m_axis_tready && (r_stat_stall != '1))
        r_stat_stall <= r_stat_stall + 32'd1;
    end
  end

  assign stat_beats = r_stat_beats;
  assign stat_stall = r_stat_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ddr_tensor_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr_tensor_writer
// Description : Scoreboard bench for ddr_tensor_writer. Expected beats are
//               pushed when an input beat is accepted and popped when the
//               DUT emits an accepted output beat.
// Options     : stat counters are checked when `WRITER_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr_tensor_writer;

  localparam int NK = 4;
  localparam int BP = 16;
  localparam int DW = 64;
  localparam int AW = 32;
  localparam int WB = 10;
  localparam int HB = 10;
  localparam int CB = 12;

  logic          clk = 1'b0;
  logic          rstn;
  logic [AW-1:0] cfg_base_addr;
  logic [WB-1:0] cfg_w;
  logic [HB-1:0] cfg_h;
  logic [CB-1:0] cfg_c;
  logic          cfg_start;
  logic          cfg_busy;
  logic          cfg_done;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic [DW+AW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
`ifdef WRITER_STATS_EN
  logic [31:0]   stat_beats;
  logic [31:0]   stat_stall;
`endif

  always #5 clk = ~clk;

  ddr_tensor_writer #(
    .N_KERNEL(NK), .B_PIXEL(BP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .W_BITS(WB), .H_BITS(HB), .C_BITS(CB)
  ) dut (
    .clk(clk), .rstn(rstn),
    .cfg_base_addr(cfg_base_addr), .cfg_w(cfg_w), .cfg_h(cfg_h), .cfg_c(cfg_c),
    .cfg_start(cfg_start), .cfg_busy(cfg_busy), .cfg_done(cfg_done),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
`ifdef WRITER_STATS_EN
    , .stat_beats(stat_beats), .stat_stall(stat_stall)
`endif
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  int total = 0;
  int bad   = 0;

  beat_t         sb[$];
  logic [AW-1:0] obs[$];

  logic [AW-1:0] m_base;
  int m_w, m_h, m_c, m_total, gen_idx, salt;
  int cyc, acc_cnt, done_cnt, stall_cnt, tvalid_seen, last_acc_cyc, done_cyc;
  bit start_req;
  bit prev_stall;
  logic [DW+AW-1:0] prev_tdata;
  logic prev_tlast;

  logic [AW-1:0] t1_addr [8];
  logic [AW-1:0] t6_addr [4];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] exp_addr(input int idx);
    int p_cnt, g, p;
    logic [AW-1:0] a;
    p_cnt = m_w * m_h;
    g = idx / p_cnt;
    p = idx % p_cnt;
    a = m_base + AW'(p) * AW'(m_c) * AW'(BP / 8) + AW'(g) * AW'(NK * BP / 8);
    return a;
  endfunction

  function automatic logic [DW-1:0] data_of(input int idx);
    logic [DW-1:0] d;
    d = {16'(idx + 16'h3000 + salt), 16'(idx + 16'h2000 + salt),
         16'(idx + 16'h1000 + salt), 16'(idx + salt)};
    return d;
  endfunction

  // One clock: drive on the falling edge, then observe what the next rising edge will do.
  task automatic step(input bit rdy);
    beat_t e;
    @(negedge clk);
    m_axis_tready = rdy;
    s_valid   = (gen_idx < m_total);
    s_data    = s_valid ? data_of(gen_idx) : '0;
    cfg_start = start_req;
    start_req = 1'b0;
    #1;
    cyc++;
    if (rstn) begin
      if (cfg_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (m_axis_tvalid) tvalid_seen++;
      if (prev_stall) begin
        check("hold_valid", m_axis_tvalid, 1);
        check("hold_data", m_axis_tdata, prev_tdata);
        check("hold_last", m_axis_tlast, prev_tlast);
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_tdata = m_axis_tdata;
      prev_tlast = m_axis_tlast;
      if (prev_stall) stall_cnt++;
      if (m_axis_tvalid && m_axis_tready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          check("addr", m_axis_tdata[DW+AW-1:DW], e.addr);
          check("data", m_axis_tdata[DW-1:0], e.data);
          check("tlast", m_axis_tlast, e.last);
        end
        obs.push_back(m_axis_tdata[DW+AW-1:DW]);
        acc_cnt++;
        if (m_axis_tlast) last_acc_cyc = cyc;
      end
      if (s_valid && s_ready) begin
        e.addr = exp_addr(gen_idx);
        e.data = s_data;
        e.last = (gen_idx == m_total - 1);
        sb.push_back(e);
        gen_idx++;
      end
    end else begin
      prev_stall = 1'b0;
    end
  endtask

  task automatic start_run(input logic [AW-1:0] base, input int w, input int h, input int c);
    cfg_base_addr = base;
    cfg_w = WB'(w);
    cfg_h = HB'(h);
    cfg_c = CB'(c);
    m_base = base;
    m_w = w;
    m_h = h;
    m_c = c;
    m_total = (w * h) * ((c + NK - 1) / NK);
    gen_idx = 0;
    salt = salt + 16'h0111;
    sb.delete();
    obs.delete();
    acc_cnt = 0;
    stall_cnt = 0;
    start_req = 1'b1;
    step(1'b1);
  endtask

  task automatic run_until_done(input int budget, input bit toggle);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++)
      step(toggle ? ((i % 2) == 0) : 1'b1);
    check("done_seen", done_cnt - d0, 1);
  endtask

  initial begin
    t1_addr = '{32'h1000, 32'h1010, 32'h1020, 32'h1030,
                32'h1008, 32'h1018, 32'h1028, 32'h1038};
    t6_addr = '{32'hFFFF_FFF0, 32'hFFFF_FFF8, 32'h0000_0000, 32'h0000_0008};
    rstn = 1'b0;
    cfg_base_addr = '0; cfg_w = '0; cfg_h = '0; cfg_c = '0; cfg_start = 1'b0;
    s_valid = 1'b0; s_data = '0; m_axis_tready = 1'b0;
    m_base = '0; m_w = 0; m_h = 0; m_c = 0; m_total = 0; gen_idx = 0; salt = 0;
    cyc = 0; acc_cnt = 0; done_cnt = 0; stall_cnt = 0; tvalid_seen = 0;
    last_acc_cyc = -1; done_cyc = -1; start_req = 1'b0; prev_stall = 1'b0;
    prev_tdata = '0; prev_tlast = 1'b0;

    // Reset state
    step(1'b1);
    step(1'b1);
    check("rst_busy", cfg_busy, 0);
    check("rst_done", cfg_done, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_tdata", m_axis_tdata, 0);
    rstn = 1'b1;

    // T1: full throughput
    start_run(32'h1000, 2, 2, 8);
    step(1'b1);
    check("t1_busy", cfg_busy, 1);
    run_until_done(100, 1'b0);
    check("t1_beats", acc_cnt, 8);
    check("t1_sb_empty", sb.size(), 0);
    check("t1_done_lat", done_cyc, last_acc_cyc + 1);
    for (int i = 0; i < 8; i++) check("t1_addr_tab", (i < obs.size()) ? obs[i] : 'x, t1_addr[i]);
    step(1'b1);
    check("t1_idle_busy", cfg_busy, 0);
    check("t1_idle_done", cfg_done, 0);

    // T2: toggling tready
    start_run(32'h1000, 2, 2, 8);
    run_until_done(200, 1'b1);
    check("t2_beats", acc_cnt, 8);
    check("t2_sb_empty", sb.size(), 0);
`ifdef WRITER_STATS_EN
    check("t2_stat_beats", stat_beats, 8);
    check("t2_stat_stall", stat_stall, stall_cnt);
`endif
    step(1'b1);

    // T3: zero channel count
    tvalid_seen = 0;
    start_run(32'h2000, 2, 2, 0);
    step(1'b1);
    check("t3_busy", cfg_busy, 1);
    check("t3_done", cfg_done, 1);
    step(1'b1);
    check("t3_busy_after", cfg_busy, 0);
    check("t3_done_after", cfg_done, 0);
    for (int i = 0; i < 3; i++) step(1'b1);
    check("t3_no_tvalid", tvalid_seen, 0);

    // T3b: zero width
    start_run(32'h2000, 0, 3, 4);
    step(1'b1);
    check("t3b_done", cfg_done, 1);
    check("t3b_tvalid", m_axis_tvalid, 0);
    step(1'b1);

    // T4: start ignored mid-run
    start_run(32'h1000, 2, 2, 8);
    step(1'b1);
    step(1'b1);
    step(1'b1);
    cfg_base_addr = 32'h9000;
    start_req = 1'b1;
    step(1'b1);
    run_until_done(100, 1'b0);
    check("t4_beats", acc_cnt, 8);
    check("t4_sb_empty", sb.size(), 0);
    for (int i = 0; i < 8; i++) check("t4_addr_tab", (i < obs.size()) ? obs[i] : 'x, t1_addr[i]);
    step(1'b1);

    // T5: reset mid-run
    begin
      int d0;
      start_run(32'h1000, 2, 2, 8);
      for (int i = 0; i < 50 && acc_cnt < 3; i++) step(1'b1);
      check("t5_pre_beats", acc_cnt, 3);
      d0 = done_cnt;
      rstn = 1'b0;
      step(1'b1);
      rstn = 1'b1;
      sb.delete();
      gen_idx = m_total;
      step(1'b1);
      check("t5_tvalid", m_axis_tvalid, 0);
      check("t5_busy", cfg_busy, 0);
      step(1'b1);
      step(1'b1);
      check("t5_no_done", done_cnt, d0);
      start_run(32'h1000, 2, 2, 8);
      run_until_done(100, 1'b0);
      check("t5_beats", acc_cnt, 8);
      for (int i = 0; i < 8; i++) check("t5_addr_tab", (i < obs.size()) ? obs[i] : 'x, t1_addr[i]);
      step(1'b1);
    end

    // T6: address wrap
    start_run(32'hFFFF_FFF0, 4, 1, 4);
    run_until_done(100, 1'b0);
    check("t6_beats", acc_cnt, 4);
    for (int i = 0; i < 4; i++) check("t6_addr_tab", (i < obs.size()) ? obs[i] : 'x, t6_addr[i]);

    // T7: non-multiple channel count, mixed backpressure
    start_run(32'h4000, 3, 2, 6);
    run_until_done(200, 1'b1);
    check("t7_beats", acc_cnt, 12);
    check("t7_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
